// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions for the rx front end (and a future tx side).
//   uart_rx_state_t  receiver FSM states
//   UART_DATA_BITS   data bits per frame
//   UART_IDLE_LEVEL  idle (mark) level of the serial line
//   maj3()           three-input majority vote
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_rx_state_t;

    localparam int unsigned UART_DATA_BITS  = 8;
    localparam logic        UART_IDLE_LEVEL = 1'b1;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/sync_ff.sv
// sync_ff: N-stage flop synchronizer for a single asynchronous bit.
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset; all stages load RESET_VALUE
//   d      in  asynchronous input
//   q      out synchronized output (STAGES cycles of latency)
module sync_ff #(
    parameter int unsigned STAGES      = 2,
    parameter logic        RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff <= {STAGES{RESET_VALUE}};
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_rx_frontend.sv
// uart_rx_frontend: 8N1 UART receiver with start-glitch rejection, 3-sample
// majority voting, stop-bit framing-error detection and line-break hold-off.
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   rx           in   raw serial line, idle high
//   data_o       out  last good byte, held until the next one
//   valid_o      out  one-cycle strobe: data_o holds a new byte
//   frame_err_o  out  one-cycle strobe: stop bit sampled low
//   busy_o       out  high from a validated start bit until back in IDLE
module uart_rx_frontend
    import uart_pkg::*;
#(
    parameter int unsigned CLOCKS_PER_BAUD = 868,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       frame_err_o,
    output logic       busy_o
);

    localparam int unsigned CNT_W = $clog2(CLOCKS_PER_BAUD);
    localparam int unsigned HALF  = CLOCKS_PER_BAUD / 2;

    localparam logic [CNT_W-1:0] CNT_LAST       = CNT_W'(CLOCKS_PER_BAUD - 1);
    localparam logic [CNT_W-1:0] CNT_START_VOTE = CNT_W'(HALF + 1);
    localparam logic [2:0]       LAST_BIT       = 3'(UART_DATA_BITS - 1);

    uart_rx_state_t   state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic [1:0]       hist;
    logic             rx_s;
    logic             vote;

    sync_ff #(
        .STAGES      (SYNC_STAGES),
        .RESET_VALUE (UART_IDLE_LEVEL)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    // The vote always covers the current rx_s and the two before it, so a
    // decision taken at count N uses samples N-2, N-1, N. In START that is
    // HALF-1..HALF+1; in DATA/STOP the decision sits on the wrap, keeping the
    // sample window one full bit period after the start-bit window.
    assign vote = maj3(hist[1], hist[0], rx_s);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            hist        <= {2{UART_IDLE_LEVEL}};
            data_o      <= '0;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            hist        <= {hist[0], rx_s};
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            cnt         <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);

            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (rx_s != UART_IDLE_LEVEL) begin
                        state <= START;
                    end
                end
                START: begin
                    if (cnt == CNT_START_VOTE) begin
                        cnt <= '0;
                        if (vote != UART_IDLE_LEVEL) begin
                            state   <= DATA;
                            bit_idx <= '0;
                            busy_o  <= 1'b1;
                        end else begin
                            state <= IDLE;  // glitch: no strobe, no busy
                        end
                    end
                end
                DATA: begin
                    if (cnt == CNT_LAST) begin
                        shreg   <= {vote, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == LAST_BIT) begin
                            state <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (cnt == CNT_LAST) begin
                        if (vote == UART_IDLE_LEVEL) begin
                            data_o  <= shreg;
                            valid_o <= 1'b1;
                            busy_o  <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            frame_err_o <= 1'b1;
                            state       <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    // Need one unbroken bit period of idle level before leaving.
                    if (rx_s != UART_IDLE_LEVEL) begin
                        cnt <= '0;
                    end else if (cnt == CNT_LAST) begin
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frontend.sv
// tb_uart_rx_frontend: directed bench for uart_rx_frontend.
// Instance a: CLOCKS_PER_BAUD=16, instance b: CLOCKS_PER_BAUD=868; both SYNC_STAGES=2.
module tb_uart_rx_frontend;

    localparam int CPB_A = 16;
    localparam int CPB_B = 868;
    localparam int SYNC  = 2;

    logic       clk;
    logic       rst_n;
    logic       rx_a, rx_b;
    logic [7:0] data_a, data_b;
    logic       valid_a, valid_b;
    logic       ferr_a, ferr_b;
    logic       busy_a, busy_b;

    int n_cmp = 0;
    int n_err = 0;

    int cyc = 0;
    int t_start = 0;
    int t_valid = 0;
    int va_cnt = 0;
    int fe_cnt = 0;
    int busy_cnt = 0;
    int overlap = 0;
    int vb_cnt = 0;
    int fb_cnt = 0;
    logic [7:0] rx_log[$];

    uart_rx_frontend #(
        .CLOCKS_PER_BAUD (CPB_A),
        .SYNC_STAGES     (SYNC)
    ) dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx          (rx_a),
        .data_o      (data_a),
        .valid_o     (valid_a),
        .frame_err_o (ferr_a),
        .busy_o      (busy_a)
    );

    uart_rx_frontend #(
        .CLOCKS_PER_BAUD (CPB_B),
        .SYNC_STAGES     (SYNC)
    ) dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx          (rx_b),
        .data_o      (data_b),
        .valid_o     (valid_b),
        .frame_err_o (ferr_b),
        .busy_o      (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid_a) begin
                va_cnt  <= va_cnt + 1;
                t_valid <= cyc;
                rx_log.push_back(data_a);
            end
            if (ferr_a) fe_cnt <= fe_cnt + 1;
            if (valid_a && ferr_a) overlap <= overlap + 1;
            if (busy_a) busy_cnt <= busy_cnt + 1;
            if (valid_b) vb_cnt <= vb_cnt + 1;
            if (ferr_b) fb_cnt <= fb_cnt + 1;
        end
    end

    task automatic check_value(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_rx(input bit which, input logic v);
        if (which) rx_b = v;
        else       rx_a = v;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one 8N1 frame; each bit is set 1 time unit after a rising edge.
    // spike: invert data bits for one cycle at their centre.
    // stop_after >= 0: return after that many driven cycles (partial frame).
    task automatic send_frame(input bit which, input logic [7:0] b, input logic stop_bit,
                              input bit spike, input int stop_after);
        int         cpb;
        int         n;
        logic [9:0] bits;
        cpb  = which ? CPB_B : CPB_A;
        bits = {stop_bit, b, 1'b0};
        n    = 0;
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < cpb; c++) begin
                if (stop_after >= 0 && n == stop_after) return;
                @(posedge clk);
                #1;
                if (i == 0 && c == 0) t_start = cyc;
                if (spike && i >= 1 && i <= 8 && c == cpb / 2) set_rx(which, ~bits[i]);
                else set_rx(which, bits[i]);
                n++;
            end
        end
    endtask

    initial begin
        int v0, f0, b0, n0, lat;
        int lat_exp;

        rst_n = 1'b0;
        rx_a  = 1'b1;
        rx_b  = 1'b1;
        idle_cycles(3);
        check_value("reset_data", data_a, 8'h00);
        check_value("reset_valid", valid_a, 1'b0);
        check_value("reset_frame_err", ferr_a, 1'b0);
        check_value("reset_busy", busy_a, 1'b0);
        check_value("reset_data_b", data_b, 8'h00);
        rst_n = 1'b1;
        idle_cycles(5);

        // 1: single frame and latency
        v0 = va_cnt;
        f0 = fe_cnt;
        send_frame(0, 8'h55, 1'b1, 0, -1);
        idle_cycles(4);
        lat_exp = SYNC + 9 * CPB_A + CPB_A / 2 + 2;
        lat     = t_valid - t_start;
        check_value("t1_valid_count", va_cnt - v0, 1);
        check_value("t1_data", data_a, 8'h55);
        check_value("t1_latency_in_window", (lat >= lat_exp - 1 && lat <= lat_exp + 1), 1);
        check_value("t1_frame_err_count", fe_cnt - f0, 0);

        // 2: back-to-back frames with a single stop bit
        v0 = va_cnt;
        n0 = rx_log.size();
        send_frame(0, 8'hA3, 1'b1, 0, -1);
        send_frame(0, 8'h00, 1'b1, 0, -1);
        send_frame(0, 8'hFF, 1'b1, 0, -1);
        idle_cycles(4);
        check_value("t2_valid_count", va_cnt - v0, 3);
        if (rx_log.size() >= n0 + 3) begin
            check_value("t2_byte0", rx_log[n0], 8'hA3);
            check_value("t2_byte1", rx_log[n0 + 1], 8'h00);
            check_value("t2_byte2", rx_log[n0 + 2], 8'hFF);
        end else begin
            check_value("t2_log_size", rx_log.size(), n0 + 3);
        end
        check_value("t2_frame_err_count", fe_cnt - f0, 0);

        // 3: start glitch of three cycles
        v0 = va_cnt;
        b0 = busy_cnt;
        rx_a = 1'b0;
        idle_cycles(3);
        rx_a = 1'b1;
        idle_cycles(3 * CPB_A);
        check_value("t3_valid_count", va_cnt - v0, 0);
        check_value("t3_busy_cycles", busy_cnt - b0, 0);
        check_value("t3_frame_err_count", fe_cnt - f0, 0);

        // 4: framing error, break recovery, next frame
        v0 = va_cnt;
        send_frame(0, 8'h3C, 1'b0, 0, -1);
        check_value("t4_busy_in_break", busy_a, 1'b1);
        rx_a = 1'b1;
        idle_cycles(16);
        check_value("t4_frame_err_count", fe_cnt - f0, 1);
        check_value("t4_data_kept", data_a, 8'hFF);
        check_value("t4_no_valid", va_cnt - v0, 0);
        send_frame(0, 8'h12, 1'b1, 0, -1);
        idle_cycles(4);
        check_value("t4_valid_count", va_cnt - v0, 1);
        check_value("t4_data", data_a, 8'h12);

        // 5: reset in the middle of bit 4
        v0 = va_cnt;
        f0 = fe_cnt;
        send_frame(0, 8'hC7, 1'b1, 0, 5 * CPB_A + CPB_A / 2);
        check_value("t5_busy_before_reset", busy_a, 1'b1);
        rst_n = 1'b0;
        rx_a  = 1'b1;
        #1;
        check_value("t5_reset_data", data_a, 8'h00);
        check_value("t5_reset_valid", valid_a, 1'b0);
        check_value("t5_reset_frame_err", ferr_a, 1'b0);
        check_value("t5_reset_busy", busy_a, 1'b0);
        idle_cycles(3);
        rst_n = 1'b1;
        idle_cycles(2 * CPB_A);
        check_value("t5_no_strobe", va_cnt - v0, 0);
        send_frame(0, 8'h81, 1'b1, 0, -1);
        idle_cycles(4);
        check_value("t5_valid_count", va_cnt - v0, 1);
        check_value("t5_data", data_a, 8'h81);
        check_value("t5_frame_err_count", fe_cnt - f0, 0);

        // 6: one-cycle spikes at each data-bit centre
        v0 = va_cnt;
        send_frame(0, 8'h5A, 1'b1, 1, -1);
        idle_cycles(4);
        check_value("t6_valid_count", va_cnt - v0, 1);
        check_value("t6_data", data_a, 8'h5A);
        check_value("t6_frame_err_count", fe_cnt - f0, 0);

        // 6b: full-rate baud divisor
        send_frame(1, 8'h55, 1'b1, 0, -1);
        idle_cycles(8);
        check_value("t6b_valid_count", vb_cnt, 1);
        check_value("t6b_data", data_b, 8'h55);
        check_value("t6b_frame_err_count", fb_cnt, 0);

        check_value("valid_frame_err_overlap", overlap, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
